xbar_rr_ctrl: RTL and testbench
===============================

XBAR_RR_CTRL -- requirements
Module: xbar_rr_ctrl

Interface
REQ-001 Parameter N_INPUTS, default 2, number of crossbar inputs arbitrated.
REQ-002 Parameter CONTROL_BIT_WIDTH, default 32, width of emitted control word.
REQ-003 Parameter BURST_LEN, default 4, max transfers per grant; legal range 1..255.
REQ-004 Derived SEL_W = clog2(N_INPUTS), minimum 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_val  input  N_INPUTS  per-input valid, tapped from upstream producers' recv_val.
REQ-008 xfer_val  input  1  crossbar output send_val.
REQ-009 xfer_rdy  input  1  crossbar output send_rdy.
REQ-010 control  output  CONTROL_BIT_WIDTH  select word for the single-output crossbar.
REQ-011 control_val  output  1  control word valid.
REQ-012 control_rdy  input  1  crossbar accepts control.
REQ-013 grant_sel  output  SEL_W  currently granted input index.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, ISSUE, HOLD; all outputs registered or decoded from registered state only.
REQ-016 control = {winner[SEL_W-1:0], zeros}: select in the SEL_W MSBs, all lower bits 0.
REQ-017 IDLE: control_val=0; if any req_val bit is high, the winner is the first set index searching ptr, ptr+1, ..., wrapping N_INPUTS-1 -> 0; winner is latched and next state is ISSUE.
REQ-018 Latency: a request first seen in IDLE at cycle t gives control_val=1 at cycle t+1.
REQ-019 ISSUE: control_val=1, control and grant_sel hold winner; stay in ISSUE until control_val && control_rdy, then go to HOLD with count=0.
REQ-020 HOLD: control_val=0; count increments on each cycle with xfer_val && xfer_rdy.
REQ-021 HOLD exit on a transfer when count == BURST_LEN-1 (burst done), or on any cycle where req_val[winner]=0 and no transfer occurs (source drained); next state IDLE.
REQ-022 Transfer and req_val[winner] drop in the same cycle: counts as a transfer; leave HOLD only if the burst is done, else leave on the next idle cycle.
REQ-023 On HOLD exit, ptr = winner+1, wrapping to 0 after N_INPUTS-1; ptr is unchanged at all other times.
REQ-024 Requests on non-granted inputs never preempt an active grant.
REQ-025 For non-power-of-2 N_INPUTS, indices >= N_INPUTS are never granted or stored in ptr.
REQ-026 count width is 8 bits and never wraps; it is cleared on entry to HOLD.
REQ-027 BURST_LEN=1: HOLD exits on the first transfer.

Reset
REQ-028 With reset high at a clock edge: state=IDLE, ptr=0, count=0, winner=0; next cycle control=0, control_val=0, grant_sel=0, busy=0.
REQ-029 Reset asserted in ISSUE or HOLD aborts the grant without updating ptr beyond its reset value 0.
REQ-030 Reset overrides all simultaneous handshakes and requests.

Structure
REQ-031 The shared package holds the FSM state enum (IDLE, ISSUE, HOLD) and the control-word select-field placement helper.
REQ-032 A combinational sub-module, xbar_rr_pick, takes req_val and ptr and returns winner plus any_req; it is instantiated once.

Verification
REQ-033 Reset: hold reset for 2 cycles with req_val=2'b11 -> control_val=0, control=0, busy=0 throughout.
REQ-034 Fairness: N=2, req_val=2'b11 held, control_rdy=1, xfer handshake every cycle, BURST_LEN=4 -> grants alternate 0,1,0,1 with 4 transfers each; control MSB toggles.
REQ-035 Backpressure: control_rdy=0 for 3 cycles in ISSUE -> control_val stays 1 and control is stable; HOLD is entered the cycle after control_rdy=1.
REQ-036 Drain: N=4, only input 2 requesting, drops req_val after 2 transfers -> return to IDLE, ptr=3; a subsequent request on input 0 only grants 0 (wrap).
REQ-037 Non-power-of-2: N=3, req_val=3'b111, full bursts -> grant order 0,1,2,0; index 3 is never issued.
REQ-038 Reset mid-HOLD after 1 of 4 transfers -> IDLE next cycle, ptr=0; the next grant with req_val=2'b11 is input 0.

Source files
------------

// File: rtl/xbar_rr_ctrl_pkg.sv
// Shared definitions for the round-robin crossbar controller:
// FSM state encoding and control-word select-field placement.
package xbar_rr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // The select field occupies the sel_w MSBs of the control word.
  // This returns the left-shift that places an index there.
  function automatic int sel_shift(input int ctrl_w, input int sel_w);
    return ctrl_w - sel_w;
  endfunction

endpackage

// File: rtl/xbar_rr_pick.sv
// Combinational round-robin picker: first requesting input found by
// searching ptr, ptr+1, ... with wrap at N_INPUTS.
module xbar_rr_pick #(
  parameter int N_INPUTS = 2,
  parameter int SEL_W    = 1
) (
  input  logic [N_INPUTS-1:0] req_val,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    winner,
  output logic                any_req
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is the final
  // assignment; ptr is always < N_INPUTS, so idx stays in range.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % N_INPUTS);
      if (req_val[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_rr_ctrl.sv
// Round-robin grant controller for a single-output crossbar: issues a
// select word, then holds the grant for up to BURST_LEN transfers.
module xbar_rr_ctrl
  import xbar_rr_ctrl_pkg::*;
#(
  parameter int N_INPUTS          = 2,
  parameter int CONTROL_BIT_WIDTH = 32,
  parameter int BURST_LEN         = 4,
  localparam int SEL_W            = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_INPUTS-1:0]          req_val,
  input  logic                         xfer_val,
  input  logic                         xfer_rdy,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  output logic [SEL_W-1:0]             grant_sel,
  output logic                         busy
);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [SEL_W-1:0] winner_reg, winner_next;
  logic [7:0]       count_reg, count_next;

  logic [SEL_W-1:0] pick_winner;
  logic             pick_any;
  logic             xfer;
  logic             burst_done;
  logic [SEL_W-1:0] ptr_after;

  xbar_rr_pick #(
    .N_INPUTS (N_INPUTS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .req_val (req_val),
    .ptr     (ptr_reg),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  assign xfer       = xfer_val && xfer_rdy;
  assign burst_done = (count_reg == 8'(BURST_LEN - 1));
  assign ptr_after  = (winner_reg == SEL_W'(N_INPUTS - 1)) ? '0 : winner_reg + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      winner_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      winner_reg <= winner_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    winner_next = winner_reg;
    count_next  = count_reg;
    unique case (state_reg)
      IDLE: begin
        if (pick_any) begin
          winner_next = pick_winner;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (control_rdy) begin
          count_next = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // A transfer always counts, even if the source drops in the same cycle.
        if (xfer) begin
          if (burst_done) begin
            state_next = IDLE;
            ptr_next   = ptr_after;
          end else begin
            count_next = count_reg + 8'd1;
          end
        end else if (!req_val[winner_reg]) begin
          state_next = IDLE;
          ptr_next   = ptr_after;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign control     = CONTROL_BIT_WIDTH'(winner_reg) << sel_shift(CONTROL_BIT_WIDTH, SEL_W);
  assign control_val = (state_reg == ISSUE);
  assign grant_sel   = winner_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_xbar_rr_ctrl.sv
// Self-checking bench for xbar_rr_ctrl (N_INPUTS=3): directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_xbar_rr_ctrl;

  localparam int N  = 3;
  localparam int CW = 32;
  localparam int BL = 4;
  localparam int SW = 2;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_val;
  logic          xfer_val;
  logic          xfer_rdy;
  logic [CW-1:0] control;
  logic          control_val;
  logic          control_rdy;
  logic [SW-1:0] grant_sel;
  logic          busy;

  xbar_rr_ctrl #(
    .N_INPUTS          (N),
    .CONTROL_BIT_WIDTH (CW),
    .BURST_LEN         (BL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .xfer_val    (xfer_val),
    .xfer_rdy    (xfer_rdy),
    .control     (control),
    .control_val (control_val),
    .control_rdy (control_rdy),
    .grant_sel   (grant_sel),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = no grant, 1 = offering select, 2 = bursting.
  int m_phase = 0;
  int m_ptr   = 0;
  int m_win   = 0;
  int m_cnt   = 0;

  int grants[$];
  int bursts[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic rst, input logic [N-1:0] rq, input logic crdy,
                              input logic xv, input logic xr);
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_win = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (rq != '0) begin
        for (int k = 0; k < N; k++) begin
          if (rq[(m_ptr + k) % N]) begin
            m_win = (m_ptr + k) % N;
            break;
          end
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (crdy) begin
        m_phase = 2;
        m_cnt = 0;
      end
    end else begin
      if (xv && xr) begin
        if (m_cnt == BL - 1) begin
          m_phase = 0;
          m_ptr = (m_win + 1) % N;
        end else begin
          m_cnt++;
        end
      end else if (!rq[m_win]) begin
        m_phase = 0;
        m_ptr = (m_win + 1) % N;
      end
    end
  endtask

  // One cycle: drive inputs at negedge, compare registered outputs with
  // the model, log transactions, then advance the model for the next edge.
  task automatic step(input logic rst, input logic [N-1:0] rq, input logic crdy,
                      input logic xv, input logic xr);
    @(negedge clk);
    reset = rst; req_val = rq; control_rdy = crdy; xfer_val = xv; xfer_rdy = xr;
    check("control_val", 32'(control_val), 32'(m_phase == 1));
    check("busy",        32'(busy),        32'(m_phase != 0));
    check("grant_sel",   32'(grant_sel),   32'(m_win));
    check("control",     control,          32'(m_win) << (CW - SW));
    if (!rst && control_val && crdy) begin
      grants.push_back(int'(grant_sel));
      bursts.push_back(0);
      $display("grant input %0d control=%h", grant_sel, control);
    end
    if (!rst && busy && !control_val && xv && xr && bursts.size() > 0)
      bursts[bursts.size() - 1] = bursts[bursts.size() - 1] + 1;
    model_update(rst, rq, crdy, xv, xr);
  endtask

  initial begin
    int n0;
    int exp_order[4];
    logic [N-1:0] rq;

    reset = 1'b1; req_val = '1; control_rdy = 1'b0; xfer_val = 1'b0; xfer_rdy = 1'b0;
    @(posedge clk);

    // Reset held two cycles with all inputs requesting.
    step(1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
    step(1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
    check("rst_ctrl", control, 32'h0);

    // Fairness: all requesting, full bursts.
    n0 = grants.size();
    repeat (24) step(1'b0, 3'b111, 1'b1, 1'b1, 1'b1);
    exp_order = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      check("fair_order", 32'(grants.size() > n0 + i ? grants[n0 + i] : -1), 32'(exp_order[i]));
      check("fair_burst", 32'(bursts.size() > n0 + i ? bursts[n0 + i] : -1), 32'(BL));
    end

    // Backpressure: control_rdy low for three ISSUE cycles.
    step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      check("bp_val",  32'(control_val), 32'd1);
      check("bp_ctrl", control, 32'h4000_0000);
    end
    step(1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    check("bp_hold_busy", 32'(busy), 32'd1);
    check("bp_hold_val",  32'(control_val), 32'd0);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    // Drain: input 2 drops together with its second transfer, then wrap to 0.
    n0 = grants.size();
    step(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b100, 1'b1, 1'b1, 1'b1);
    step(1'b0, 3'b000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    check("drain_busy", 32'(busy), 32'd1);
    step(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    check("drain_idle", 32'(busy), 32'd0);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    check("drain_grant", 32'(grants.size() > n0 ? grants[n0] : -1), 32'd2);
    check("drain_xfers", 32'(bursts.size() > n0 ? bursts[n0] : -1), 32'd2);
    check("wrap_grant",  32'(grants.size() > n0 + 1 ? grants[n0 + 1] : -1), 32'd0);

    // Reset in the middle of a burst granted to input 1.
    n0 = grants.size();
    step(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b111, 1'b1, 1'b1, 1'b1);
    step(1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
    step(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    check("rst_mid_idle", 32'(busy), 32'd0);
    step(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    check("pre_rst_grant",  32'(grants.size() > n0 ? grants[n0] : -1), 32'd1);
    check("post_rst_grant", 32'(grants.size() > n0 + 1 ? grants[n0 + 1] : -1), 32'd0);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rq = N'($urandom_range(0, 7));
      step(($urandom_range(0, 49) == 0), rq, ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom));
    end
    foreach (grants[i]) check("grant_range", 32'(grants[i] < N), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
